// File: rtl/wb_hls_div_master.sv
// Wishbone master that feeds (a,b) jobs to the HLS divider peripheral and returns quotients.
// Verifies the peripheral core ID after reset, then runs write A/B, start, poll, read C per job.
module wb_hls_div_master #(
   parameter int          WB_ADR_WIDTH = 6,
   parameter int          WB_DAT_WIDTH = 32,
   parameter int          WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
   parameter int          POLL_LIMIT   = 1024,
   parameter logic [31:0] CORE_ID      = 32'haa551234
) (
   input  logic                    reset,
   input  logic                    clk,
   input  logic [31:0]             s_a,
   input  logic [31:0]             s_b,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [31:0]             m_c,
   output logic                    m_timeout,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
   output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
   output logic                    m_wb_we_o,
   output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
   output logic                    m_wb_stb_o,
   input  logic                    m_wb_ack_i,
   output logic                    busy,
   output logic                    err
);

   localparam int PW = $clog2(POLL_LIMIT + 1);

   localparam logic [WB_ADR_WIDTH-1:0] ADR_ID     = WB_ADR_WIDTH'(0);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_CTRL   = WB_ADR_WIDTH'(4);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS = WB_ADR_WIDTH'(5);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_A      = WB_ADR_WIDTH'(8);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_B      = WB_ADR_WIDTH'(9);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_C      = WB_ADR_WIDTH'(10);

   typedef enum logic [3:0] {
      ST_ID_CHK,
      ST_IDLE,
      ST_WR_A,
      ST_WR_B,
      ST_START,
      ST_POLL,
      ST_RD_C,
      ST_OUT,
      ST_ERROR
   } state_e;

   state_e                  state_q;
   logic [31:0]             a_q, b_q;
   logic [PW-1:0]           poll_cnt_q;
   logic                    stb_q, we_q, s_ready_q, m_valid_q, m_timeout_q, busy_q, err_q;
   logic [WB_ADR_WIDTH-1:0] adr_q;
   logic [WB_DAT_WIDTH-1:0] dat_q;
   logic [WB_SEL_WIDTH-1:0] sel_q;
   logic [31:0]             m_c_q;

   logic [WB_ADR_WIDTH-1:0] req_adr_d;
   logic [WB_DAT_WIDTH-1:0] req_dat_d;
   logic                    req_we_d;

   // Bus request implied by the current state; latched into the _q outputs when stb rises.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      req_adr_d = ADR_ID;
      req_dat_d = '0;
      req_we_d  = 1'b0;
      unique case (state_q)
         ST_WR_A: begin
            req_adr_d       = ADR_A;
            req_dat_d[31:0] = a_q;
            req_we_d        = 1'b1;
         end
         ST_WR_B: begin
            req_adr_d       = ADR_B;
            req_dat_d[31:0] = b_q;
            req_we_d        = 1'b1;
         end
         ST_START: begin
            req_adr_d    = ADR_CTRL;
            req_dat_d[0] = 1'b1;
            req_we_d     = 1'b1;
         end
         ST_POLL: req_adr_d = ADR_STATUS;
         ST_RD_C: req_adr_d = ADR_C;
         default: ;
      endcase
   end

   // Bus states raise stb from an idle bus, so every transaction is preceded by one low cycle.
   // NOTE: sequential state uses non-blocking assignments only, so ordering inside the block never matters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ID_CHK;
         a_q         <= '0;
         b_q         <= '0;
         poll_cnt_q  <= '0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         s_ready_q   <= 1'b0;
         m_valid_q   <= 1'b0;
         m_timeout_q <= 1'b0;
         m_c_q       <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (!stb_q) begin
         unique case (state_q)
            ST_IDLE: begin
               if (s_valid && s_ready_q) begin
                  a_q       <= s_a;
                  b_q       <= s_b;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_WR_A;
               end
            end
            ST_OUT: begin
               if (m_ready) begin
                  m_valid_q <= 1'b0;
                  s_ready_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            ST_ERROR: ;
            default: begin
               stb_q  <= 1'b1;
               adr_q  <= req_adr_d;
               dat_q  <= req_dat_d;
               we_q   <= req_we_d;
               sel_q  <= '1;
               busy_q <= 1'b1;
            end
         endcase
      end else if (m_wb_ack_i) begin
         stb_q <= 1'b0;
         unique case (state_q)
            ST_ID_CHK: begin
               busy_q <= 1'b0;
               if (m_wb_dat_i[31:0] == CORE_ID) begin
                  s_ready_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  err_q   <= 1'b1;
                  state_q <= ST_ERROR;
               end
            end
            ST_WR_A:  state_q <= ST_WR_B;
            ST_WR_B:  state_q <= ST_START;
            ST_START: begin
               poll_cnt_q <= '0;
               state_q    <= ST_POLL;
            end
            ST_POLL: begin
               poll_cnt_q <= poll_cnt_q + 1'b1;
               if (m_wb_dat_i[0]) begin
                  state_q <= ST_RD_C;
               end else if (poll_cnt_q == PW'(POLL_LIMIT - 1)) begin
                  m_c_q       <= '0;
                  m_timeout_q <= 1'b1;
                  m_valid_q   <= 1'b1;
                  state_q     <= ST_OUT;
               end
            end
            ST_RD_C: begin
               m_c_q       <= m_wb_dat_i[31:0];
               m_timeout_q <= 1'b0;
               m_valid_q   <= 1'b1;
               state_q     <= ST_OUT;
            end
            default: ;
         endcase
      end
   end

   assign s_ready    = s_ready_q;
   assign m_c        = m_c_q;
   assign m_timeout  = m_timeout_q;
   assign m_valid    = m_valid_q;
   assign m_wb_adr_o = adr_q;
   assign m_wb_dat_o = dat_q;
   assign m_wb_we_o  = we_q;
   assign m_wb_sel_o = sel_q;
   assign m_wb_stb_o = stb_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: doc/wb_hls_div_master.md
Name: wb_hls_div_master

Overview:
Wishbone master that drives the HLS divider test peripheral (core-ID/control/status/A/B/C register map) on behalf of a stream client. It accepts (a,b) operand pairs on a valid/ready input stream, then runs the bus sequence: write A, write B, pulse start, poll status until done, read C. It returns the quotient on a valid/ready output stream. After reset it first verifies the peripheral's core ID. The block sits between a host-side job stream and the divider peripheral's Wishbone slave port.

Parameters:
WB_ADR_WIDTH, 6, Wishbone word-address width
WB_DAT_WIDTH, 32, Wishbone data width (must be >= 32)
WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width
POLL_LIMIT, 1024, maximum status reads per job before timeout (>= 1)
CORE_ID, 32'haa551234, expected value at core-ID register

Ports:
reset  in  1  synchronous, active-high reset
clk  in  1  clock
s_a  in  32  dividend
s_b  in  32  divisor
s_valid  in  1  operand pair valid
s_ready  out  1  operand pair accepted when s_valid && s_ready
m_c  out  32  result read from C register (0 on timeout)
m_timeout  out  1  result is a timeout, not a quotient
m_valid  out  1  result valid
m_ready  in  1  result consumed when m_valid && m_ready
m_wb_adr_o  out  WB_ADR_WIDTH  word address
m_wb_dat_o  out  WB_DAT_WIDTH  write data
m_wb_dat_i  in  WB_DAT_WIDTH  read data, sampled on ack
m_wb_we_o  out  1  write enable
m_wb_sel_o  out  WB_SEL_WIDTH  byte select
m_wb_stb_o  out  1  strobe
m_wb_ack_i  in  1  acknowledge
busy  out  1  high in any state other than IDLE and ERROR
err  out  1  sticky core-ID mismatch flag

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Register map (word addresses): CORE_ID=0, CONTROL=4, STATUS=5, A=8, B=9, C=10. STATUS bit0 means done.
- Reset values: stb=0, we=0, adr=0, dat_o=0, sel=0, s_ready=0, m_valid=0, m_timeout=0, m_c=0, busy=0, err=0. The state machine goes to ID_CHK.
- All outputs are registered.
- Bus transaction rules:
  - stb is held with constant adr/we/sel/dat_o until ack.
  - stb drops on the clock edge that samples ack.
  - stb stays low exactly one cycle before the next transaction.
  - Single transactions only; sel is all ones on every transaction.
- ID_CHK: read adr 0.
  - On ack, if dat_i[31:0]==CORE_ID, go to IDLE.
  - Otherwise go to ERROR: err=1, s_ready=0 permanently, no bus activity until reset.
- IDLE: s_ready=1. On accept, capture a and b, set s_ready=0, go to WR_A.
- WR_A: write a to adr 8. Then WR_B: write b to adr 9.
- START: write 1 to adr 4.
- POLL: read adr 5; poll counter starts at 0 and increments on each ack.
  - If dat_i[0]=1, go to RD_C.
  - Else, if counter==POLL_LIMIT, go to OUT with m_c=0 and m_timeout=1, skipping RD_C.
  - Otherwise issue another read after the one-cycle gap.
- RD_C: read adr 10; dat_i[31:0] goes to m_c, m_timeout=0. Then OUT.
- OUT: m_valid=1 with m_c and m_timeout stable until m_ready.
  - On handshake, m_valid=0 on the next edge; go to IDLE.
  - s_ready rises on the cycle after the handshake; no overlap of jobs.
- Latency with a combinational-ack slave (ack=stb), done on first poll, accept at edge T:
  - stb cycles at T+1, T+3, T+5, T+7, T+9;
  - m_valid high from T+10.
- A slow slave stretches each transaction by its ack delay; there is no bus timeout.
- ack while stb=0 is ignored.
- Reset mid-transaction: all outputs return to reset values on that edge (stb drops); the ID check is re-run.
- Divisor 0 is passed through unchanged; the result is whatever the peripheral returns.
- s_valid while s_ready=0 is held off; a and b are not sampled.

Test Plan:
- After reset, slave returns 0xaa551234 at adr 0 -> s_ready=1 at cycle 3 after reset release; err=0.
- After reset, slave returns 0x12345678 at adr 0 -> err=1, s_ready stays 0, no stb for 100 cycles.
- a=100, b=7, ack=stb, done on first poll -> bus sequence is W8=100, W9=7, W4=1, R5, R10; m_valid at T+10 with m_c=14, m_timeout=0.
- Done returned on the 3rd poll and slave ack delayed 2 cycles -> exactly 3 reads of adr 5, each stb held 3 cycles, one gap cycle between transactions; m_c correct.
- POLL_LIMIT=4, done never set -> exactly 4 status reads, no adr 10 read; m_valid with m_timeout=1, m_c=0.
- m_ready held low 5 cycles, then reset asserted during WR_B of the next job -> m_c stable while waiting; stb=0 after reset edge; ID check reissued.
